// File: rtl/filter_mc_apb_reg_pkg.sv
// Register map, field layout and shared types for the multi-channel filter APB block.
package filter_mc_apb_reg_pkg;

  // Byte addresses of the register map
  localparam logic [7:0] ADDR_CTRL        = 8'h10;
  localparam logic [7:0] ADDR_CFG         = 8'h14;
  localparam logic [7:0] ADDR_FILT_CTRL   = 8'h18;
  localparam logic [7:0] ADDR_GAIN        = 8'h1C;
  localparam logic [7:0] ADDR_TABLE_CFG   = 8'h40;
  localparam logic [7:0] ADDR_TABLE_ADDR  = 8'h44;
  localparam logic [7:0] ADDR_TABLE_WR    = 8'h48;
  localparam logic [7:0] ADDR_TABLE_WRINC = 8'h4C;
  localparam logic [7:0] ADDR_TABLE_WRDEC = 8'h50;
  localparam logic [7:0] ADDR_TABLE_RD    = 8'h54;
  localparam logic [7:0] ADDR_TABLE_RDINC = 8'h58;
  localparam logic [7:0] ADDR_TABLE_RDDEC = 8'h5C;
  localparam logic [7:0] ADDR_TEST        = 8'hF0;
  localparam logic [7:0] ADDR_REGINFO     = 8'hF8;
  localparam logic [7:0] ADDR_ID          = 8'hFC;

  // Word indices (byte address bits [7:2]) used by the decoder
  localparam logic [5:0] W_CTRL        = ADDR_CTRL[7:2];
  localparam logic [5:0] W_CFG         = ADDR_CFG[7:2];
  localparam logic [5:0] W_FILT_CTRL   = ADDR_FILT_CTRL[7:2];
  localparam logic [5:0] W_GAIN        = ADDR_GAIN[7:2];
  localparam logic [5:0] W_TABLE_CFG   = ADDR_TABLE_CFG[7:2];
  localparam logic [5:0] W_TABLE_ADDR  = ADDR_TABLE_ADDR[7:2];
  localparam logic [5:0] W_TABLE_WR    = ADDR_TABLE_WR[7:2];
  localparam logic [5:0] W_TABLE_WRINC = ADDR_TABLE_WRINC[7:2];
  localparam logic [5:0] W_TABLE_WRDEC = ADDR_TABLE_WRDEC[7:2];
  localparam logic [5:0] W_TABLE_RD    = ADDR_TABLE_RD[7:2];
  localparam logic [5:0] W_TABLE_RDINC = ADDR_TABLE_RDINC[7:2];
  localparam logic [5:0] W_TABLE_RDDEC = ADDR_TABLE_RDDEC[7:2];
  localparam logic [5:0] W_TEST        = ADDR_TEST[7:2];
  localparam logic [5:0] W_REGINFO     = ADDR_REGINFO[7:2];
  localparam logic [5:0] W_ID          = ADDR_ID[7:2];

  // Field positions, masks and reset values
  localparam int         CTRL_FILT_EN_SHFT  = 0;
  localparam int         CTRL_CLKOFF_SHFT   = 1;
  localparam int         CTRL_BYPASS_SHFT   = 2;
  localparam logic [2:0] CTRL_RESET         = 3'b110;
  localparam int         CFG_DELAY_SEL_SHFT = 0;
  localparam int         CFG_DELAY_VAL_SHFT = 8;
  localparam logic [4:0] CFG_DELAY_VAL_MSK  = 5'h1F;
  localparam int         GAIN_VAL_SHFT      = 0;
  localparam logic [5:0] GAIN_VAL_MSK       = 6'h3F;
  localparam logic [5:0] GAIN_RESET         = 6'h04;
  localparam int         TABLE_DIRECT_SHFT  = 0;
  localparam int         TEST_CLKOFF_SHFT   = 0;
  localparam logic [7:0] ID_LOW_BYTE        = 8'h0A;

  // Table access FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_DONE = 3'd4
  } tbl_state_t;

  // Address post-update applied when a table access completes
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2
  } tbl_step_t;

endpackage

// File: rtl/filter_tbl_access.sv
// Coefficient table access engine: sequences SRAM writes/reads, waits out the
// read latency, captures read data and post-updates the table address.
module filter_tbl_access
  import filter_mc_apb_reg_pkg::*;
#(
  parameter int TABLE_AW   = 8,
  parameter int TABLE_DW   = 24,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_wr,
  input  logic                start_rd,
  input  tbl_step_t           step,
  input  logic [TABLE_DW-1:0] wdata,
  input  logic                addr_we,
  input  logic [TABLE_AW-1:0] addr_wdata,
  input  logic [TABLE_DW-1:0] mem_rdata_i,
  output tbl_state_t          state,
  output logic [TABLE_AW-1:0] tbl_addr,
  output logic [TABLE_DW-1:0] rd_data,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [TABLE_AW-1:0] mem_addr_o,
  output logic [TABLE_DW-1:0] mem_wdata_o
);

  // Last value of the latency counter; MEM_RD_LAT is limited to 1..3
  localparam logic [1:0] LAT_LAST = 2'(MEM_RD_LAT - 1);

  tbl_step_t           step_q;
  logic [1:0]          lat_cnt;
  logic [TABLE_AW-1:0] next_addr;

  // Post-update address; wraps naturally modulo 2^TABLE_AW
  always_comb begin
    next_addr = tbl_addr;
    case (step_q)
      STEP_INC: next_addr = tbl_addr + TABLE_AW'(1);
      STEP_DEC: next_addr = tbl_addr - TABLE_AW'(1);
      default:  next_addr = tbl_addr;
    endcase
  end

  // Access FSM with registered SRAM strobes; the address register lives here so
  // the APB write and the post-update never race.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      step_q      <= STEP_NONE;
      lat_cnt     <= '0;
      tbl_addr    <= '0;
      rd_data     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_wr) begin
            state       <= WR;
            step_q      <= step;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= tbl_addr;
            mem_wdata_o <= wdata;
          end else if (start_rd) begin
            state      <= RD_REQ;
            step_q     <= step;
            mem_req_o  <= 1'b1;
            mem_addr_o <= tbl_addr;
          end else if (addr_we) begin
            tbl_addr <= addr_wdata;
          end
        end
        WR: begin
          state    <= IDLE;
          tbl_addr <= next_addr;
        end
        RD_REQ: begin
          state   <= RD_WAIT;
          lat_cnt <= '0;
        end
        RD_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rd_data <= mem_rdata_i;
            state   <= RD_DONE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        RD_DONE: begin
          state    <= IDLE;
          tbl_addr <= next_addr;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/filter_apb_regs_mc.sv
// APB slave for the multi-channel filter: register bank, address decode and
// read mux, with coefficient table accesses delegated to filter_tbl_access.
//
// Handshake: a transfer is in its access phase while psel & penable are high;
// it completes on the first such cycle with pready=1. prdata and pslverr carry
// meaning only in that completing cycle and are 0 at all other times.
module filter_apb_regs_mc
  import filter_mc_apb_reg_pkg::*;
#(
  parameter int          NUM_FILT     = 18,
  parameter int          TABLE_AW     = 8,
  parameter int          TABLE_DW     = 24,
  parameter int          MEM_RD_LAT   = 1,
  parameter logic [7:0]  ID_VERSION   = 8'h03,
  parameter logic [17:0] REGINFO_DATE = 18'd0
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [7:0]          paddr,
  input  logic [31:0]         pwdata,
  output logic [31:0]         prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                filt_en_o,
  output logic                clkoff_o,
  output logic                bypass_o,
  output logic [NUM_FILT-1:0] filt_ch_en_o,
  output logic                delay_sel_o,
  output logic [4:0]          delay_val_o,
  output logic [5:0]          gain_o,
  output logic                tbl_direct_o,
  output logic                test_filtclkoff_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [TABLE_AW-1:0] mem_addr_o,
  output logic [TABLE_DW-1:0] mem_wdata_o,
  input  logic [TABLE_DW-1:0] mem_rdata_i
);

  tbl_state_t          state;
  tbl_step_t           step;
  logic [TABLE_AW-1:0] tbl_addr;
  logic [TABLE_DW-1:0] rd_data;
  logic [5:0]          word;
  logic                access, idle;
  logic                hit_tbl_wr, hit_tbl_rd, mapped;
  logic                tbl_req, start_wr, start_rd, reg_wr;
  logic [31:0]         reg_rdata;
  logic                unused_ok;

  assign word      = paddr[7:2];
  assign access    = psel & penable;
  assign idle      = (state == IDLE);
  assign unused_ok = ^{pwdata, paddr[1:0]};

  // Address decode and INC/DEC selection
  always_comb begin
    hit_tbl_wr = (word == W_TABLE_WR) || (word == W_TABLE_WRINC) || (word == W_TABLE_WRDEC);
    hit_tbl_rd = (word == W_TABLE_RD) || (word == W_TABLE_RDINC) || (word == W_TABLE_RDDEC);
    mapped     = hit_tbl_wr || hit_tbl_rd ||
                 (word == W_CTRL) || (word == W_CFG) || (word == W_FILT_CTRL) ||
                 (word == W_GAIN) || (word == W_TABLE_CFG) || (word == W_TABLE_ADDR) ||
                 (word == W_TEST) || (word == W_REGINFO) || (word == W_ID);
    step = STEP_NONE;
    if ((word == W_TABLE_WRINC) || (word == W_TABLE_RDINC)) step = STEP_INC;
    if ((word == W_TABLE_WRDEC) || (word == W_TABLE_RDDEC)) step = STEP_DEC;
  end

  // Only writes to TABLE_WR* and reads of TABLE_RD* touch the SRAM
  assign tbl_req  = idle & access & ((pwrite & hit_tbl_wr) | (~pwrite & hit_tbl_rd));
  assign start_wr = tbl_req & pwrite & tbl_direct_o;
  assign start_rd = tbl_req & ~pwrite & tbl_direct_o;
  assign reg_wr   = idle & access & pwrite;

  // Register bank; RO and TABLE_RD* words fall through to the default
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      filt_en_o         <= CTRL_RESET[CTRL_FILT_EN_SHFT];
      clkoff_o          <= CTRL_RESET[CTRL_CLKOFF_SHFT];
      bypass_o          <= CTRL_RESET[CTRL_BYPASS_SHFT];
      filt_ch_en_o      <= '0;
      delay_sel_o       <= 1'b0;
      delay_val_o       <= '0;
      gain_o            <= GAIN_RESET;
      tbl_direct_o      <= 1'b0;
      test_filtclkoff_o <= 1'b0;
    end else if (reg_wr) begin
      case (word)
        W_CTRL: begin
          filt_en_o <= pwdata[CTRL_FILT_EN_SHFT];
          clkoff_o  <= pwdata[CTRL_CLKOFF_SHFT];
          bypass_o  <= pwdata[CTRL_BYPASS_SHFT];
        end
        W_CFG: begin
          delay_sel_o <= pwdata[CFG_DELAY_SEL_SHFT];
          delay_val_o <= pwdata[CFG_DELAY_VAL_SHFT +: 5] & CFG_DELAY_VAL_MSK;
        end
        W_FILT_CTRL: filt_ch_en_o      <= pwdata[NUM_FILT-1:0];
        W_GAIN:      gain_o            <= pwdata[GAIN_VAL_SHFT +: 6] & GAIN_VAL_MSK;
        W_TABLE_CFG: tbl_direct_o      <= pwdata[TABLE_DIRECT_SHFT];
        W_TEST:      test_filtclkoff_o <= pwdata[TEST_CLKOFF_SHFT];
        default: ;
      endcase
    end
  end

  // Plain register read mux; unimplemented bits and TABLE_WR* read as 0
  always_comb begin
    reg_rdata = '0;
    case (word)
      W_CTRL:       reg_rdata = {29'd0, bypass_o, clkoff_o, filt_en_o};
      W_CFG:        reg_rdata = {19'd0, delay_val_o, 7'd0, delay_sel_o};
      W_FILT_CTRL:  reg_rdata = 32'(filt_ch_en_o);
      W_GAIN:       reg_rdata = {26'd0, gain_o};
      W_TABLE_CFG:  reg_rdata = {31'd0, tbl_direct_o};
      W_TABLE_ADDR: reg_rdata = 32'(tbl_addr);
      W_TEST:       reg_rdata = {31'd0, test_filtclkoff_o};
      W_REGINFO:    reg_rdata = {14'd0, REGINFO_DATE};
      W_ID:         reg_rdata = {16'd0, ID_VERSION, ID_LOW_BYTE};
      default:      reg_rdata = '0;
    endcase
  end

  // APB response: ready/data/error derived from FSM state and current request
  always_comb begin
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    case (state)
      IDLE: begin
        pready  = ~(start_wr | start_rd);
        pslverr = access & (~mapped | (tbl_req & ~tbl_direct_o));
        if (access && !pwrite && mapped && !tbl_req) prdata = reg_rdata;
      end
      WR:      pready = 1'b1;
      RD_DONE: begin
        pready = 1'b1;
        prdata = 32'(rd_data);
      end
      default: pready = 1'b0;
    endcase
  end

  filter_tbl_access #(
    .TABLE_AW  (TABLE_AW),
    .TABLE_DW  (TABLE_DW),
    .MEM_RD_LAT(MEM_RD_LAT)
  ) u_tbl (
    .clk        (pclk),
    .rst_n      (presetn),
    .start_wr   (start_wr),
    .start_rd   (start_rd),
    .step       (step),
    .wdata      (pwdata[TABLE_DW-1:0]),
    .addr_we    (reg_wr && (word == W_TABLE_ADDR)),
    .addr_wdata (pwdata[TABLE_AW-1:0]),
    .mem_rdata_i(mem_rdata_i),
    .state      (state),
    .tbl_addr   (tbl_addr),
    .rd_data    (rd_data),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o)
  );

endmodule

// File: tb/tb_filter_apb_regs_mc.sv
// Bench for filter_apb_regs_mc: directed scenarios plus random register/table
// traffic against a register-map level model and a behavioural SRAM.
module tb_filter_apb_regs_mc;

  localparam int LAT   = 2;
  localparam int EXP_W = 38;  // {is_read, err, waits[3:0], rdata[31:0]}
  localparam int MEM_W = 33;  // {we, addr[7:0], wdata[23:0]}

  // ---------------- clock / reset ----------------
  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  always #5 pclk = ~pclk;

  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        filt_en_o, clkoff_o, bypass_o;
  logic [17:0] filt_ch_en_o;
  logic        delay_sel_o;
  logic [4:0]  delay_val_o;
  logic [5:0]  gain_o;
  logic        tbl_direct_o, test_filtclkoff_o;
  logic        mem_req_o, mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [23:0] mem_wdata_o;
  logic [23:0] mem_rdata_i;

  filter_apb_regs_mc #(
    .NUM_FILT(18), .TABLE_AW(8), .TABLE_DW(24), .MEM_RD_LAT(LAT),
    .ID_VERSION(8'h03), .REGINFO_DATE(18'd0)
  ) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .filt_en_o(filt_en_o), .clkoff_o(clkoff_o), .bypass_o(bypass_o),
    .filt_ch_en_o(filt_ch_en_o), .delay_sel_o(delay_sel_o), .delay_val_o(delay_val_o),
    .gain_o(gain_o), .tbl_direct_o(tbl_direct_o), .test_filtclkoff_o(test_filtclkoff_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // ---------------- behavioural SRAM ----------------
  logic [23:0] sram [256];
  logic [23:0] pipe_d [3];
  logic        pipe_v [3];
  logic [23:0] junk;

  always @(posedge pclk) begin
    if (mem_req_o && mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
    pipe_v[0] <= mem_req_o && !mem_we_o;
    pipe_d[0] <= sram[mem_addr_o];
    for (int i = 1; i < 3; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    junk <= 24'($urandom);
  end

  // Data is only meaningful in its one valid cycle; otherwise noise
  always_comb mem_rdata_i = pipe_v[LAT-1] ? pipe_d[LAT-1] : junk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [MEM_W-1:0] exp_mem_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (register-map level) ----------------
  logic [31:0] m_reg [256];
  logic [23:0] m_mem [256];

  function automatic logic [31:0] rw_mask(input logic [7:0] a);
    case (a)
      8'h10:   return 32'h7;
      8'h14:   return 32'h1F01;
      8'h18:   return 32'h3FFFF;
      8'h1C:   return 32'h3F;
      8'h40:   return 32'h1;
      8'h44:   return 32'hFF;
      8'hF0:   return 32'h1;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_mapped(input logic [7:0] a);
    case (a)
      8'h10, 8'h14, 8'h18, 8'h1C, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h50,
      8'h54, 8'h58, 8'h5C, 8'hF0, 8'hF8, 8'hFC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_reg[i] = 32'h0;
    m_reg[8'h10] = 32'h6;
    m_reg[8'h1C] = 32'h4;
    m_reg[8'hFC] = 32'h030A;
  endtask

  // Apply one APB transfer to the model and queue what the DUT must show
  task automatic model_access(input logic [7:0] a_in, input logic w, input logic [31:0] d);
    logic [7:0]  a;
    logic [31:0] rd;
    logic        err;
    int          waits;
    bit          tbl;
    int          ad;
    a = {a_in[7:2], 2'b00};
    rd = 32'h0; err = 1'b0; waits = 0;
    tbl = (w && (a == 8'h48 || a == 8'h4C || a == 8'h50)) ||
          (!w && (a == 8'h54 || a == 8'h58 || a == 8'h5C));
    if (!is_mapped(a)) begin
      err = 1'b1;
    end else if (tbl) begin
      if (m_reg[8'h40][0] == 1'b0) begin
        err = 1'b1;
      end else begin
        ad = int'(m_reg[8'h44]);
        if (w) begin
          waits = 1;
          m_mem[ad] = d[23:0];
          exp_mem_q.push_back({1'b1, 8'(ad), d[23:0]});
        end else begin
          waits = LAT + 2;
          rd = 32'(m_mem[ad]);
          exp_mem_q.push_back({1'b0, 8'(ad), 24'h0});
        end
        if (a == 8'h4C || a == 8'h58) m_reg[8'h44] = 32'((ad + 1) % 256);
        if (a == 8'h50 || a == 8'h5C) m_reg[8'h44] = 32'((ad + 255) % 256);
      end
    end else if (w) begin
      if (rw_mask(a) != 32'h0) m_reg[a] = d & rw_mask(a);
    end else begin
      rd = m_reg[a];
    end
    exp_q.push_back({!w, err, 4'(waits), rd});
  endtask

  // ---------------- driver ----------------
  task automatic apb(input logic [7:0] a, input logic w, input logic [31:0] d);
    int n;
    model_access(a, w, d);
    paddr = a; pwrite = w; pwdata = d; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    n = 0;
    @(negedge pclk);
    while (!pready && n < 20) begin
      n++;
      @(negedge pclk);
    end
    if (!pready) begin
      n_tests++; n_fail++;
      $display("FAIL apb_timeout: addr 0x%0h no pready after %0d cycles", a, n);
    end
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_outs();
    check("ctrl_out", 64'({bypass_o, clkoff_o, filt_en_o}), 64'(m_reg[8'h10][2:0]));
    check("ch_en_out", 64'(filt_ch_en_o), 64'(m_reg[8'h18][17:0]));
    check("cfg_out", 64'({delay_val_o, delay_sel_o}), 64'({m_reg[8'h14][12:8], m_reg[8'h14][0]}));
    check("gain_out", 64'(gain_o), 64'(m_reg[8'h1C][5:0]));
    check("direct_out", 64'(tbl_direct_o), 64'(m_reg[8'h40][0]));
    check("test_out", 64'(test_filtclkoff_o), 64'(m_reg[8'hF0][0]));
  endtask

  // ---------------- APB monitor ----------------
  int cyc = 0;
  always @(negedge pclk) begin
    logic [EXP_W-1:0] e;
    if (presetn && psel && penable) begin
      if (pready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL apb_unexpected: completion at addr 0x%0h with nothing expected", paddr);
        end else begin
          e = exp_q.pop_front();
          if (e[37]) check("prdata", 64'(prdata), 64'(e[31:0]));
          check("pslverr", 64'(pslverr), 64'(e[36]));
          check("wait_states", 64'(cyc), 64'(e[35:32]));
        end
        cyc = 0;
      end else begin
        check("prdata_not_ready", 64'(prdata), 64'(0));
        cyc++;
      end
    end else begin
      cyc = 0;
    end
  end

  // ---------------- SRAM strobe monitor ----------------
  always @(negedge pclk) begin
    logic [MEM_W-1:0] m;
    if (presetn && mem_req_o) begin
      if (exp_mem_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mem_unexpected: strobe we=%0d addr 0x%0h", mem_we_o, mem_addr_o);
      end else begin
        m = exp_mem_q.pop_front();
        check("mem_we", 64'(mem_we_o), 64'(m[32]));
        check("mem_addr", 64'(mem_addr_o), 64'(m[31:24]));
        if (m[32]) check("mem_wdata", 64'(mem_wdata_o), 64'(m[23:0]));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [7:0] addr_tbl [19] = '{8'h10, 8'h14, 8'h18, 8'h1C, 8'h40, 8'h44, 8'h48, 8'h4C,
                                8'h50, 8'h54, 8'h58, 8'h5C, 8'hF0, 8'hF8, 8'hFC, 8'h20,
                                8'h00, 8'h60, 8'hE4};

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    logic        w;

    model_reset();
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_pready", 64'(pready), 64'(1));
    check("rst_prdata", 64'(prdata), 64'(0));
    check("rst_pslverr", 64'(pslverr), 64'(0));
    check("rst_mem_req", 64'(mem_req_o), 64'(0));
    check("rst_mem_we", 64'(mem_we_o), 64'(0));
    check("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata_o), 64'(0));
    check_outs();
    @(posedge pclk); #1 presetn = 1'b1;

    // Every register at its reset value
    foreach (addr_tbl[i]) if (i < 15) apb(addr_tbl[i], 1'b0, 32'h0);

    // Channel enable width clipping
    apb(8'h18, 1'b1, 32'hFFFF_FFFF);
    apb(8'h18, 1'b0, 32'h0);
    check_outs();

    // Table access with DIRECT=0 and an unmapped read
    apb(8'h48, 1'b1, 32'h0055_AA55);
    apb(8'h20, 1'b0, 32'h0);
    apb(8'h44, 1'b0, 32'h0);

    // Fill the whole table with WRINC; address wraps back to 0
    apb(8'h40, 1'b1, 32'h1);
    for (int i = 0; i < 256; i++) apb(8'h4C, 1'b1, $urandom);
    apb(8'h44, 1'b0, 32'h0);

    // WRINC at the top address wraps to 0
    apb(8'h44, 1'b1, 32'hFF);
    apb(8'h4C, 1'b1, 32'h0012_3456);
    apb(8'h44, 1'b0, 32'h0);

    // RDDEC at address 0 wraps to max
    apb(8'h48, 1'b1, 32'h00AB_CDEF);
    apb(8'h5C, 1'b0, 32'h0);
    apb(8'h44, 1'b0, 32'h0);

    // Cross-direction table words are plain accesses
    apb(8'h54, 1'b1, 32'h1234);
    apb(8'h4C, 1'b0, 32'h0);
    apb(8'h44, 1'b0, 32'h0);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      a = addr_tbl[$urandom_range(0, 18)];
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (a == 8'h40) d[0] = ($urandom_range(0, 3) != 0);
      apb(a, w, d);
      if (w) check_outs();
    end

    // Reset while a table read is waiting on the SRAM
    apb(8'h40, 1'b1, 32'h1);
    apb(8'h44, 1'b1, 32'h37);
    exp_mem_q.push_back({1'b0, m_reg[8'h44][7:0], 24'h0});
    paddr = 8'h58; pwrite = 1'b0; pwdata = 32'h0; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk);
    @(posedge pclk); #1;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    check("midrst_mem_req", 64'(mem_req_o), 64'(0));
    check("midrst_pready", 64'(pready), 64'(1));
    check("midrst_mem_addr", 64'(mem_addr_o), 64'(0));
    check("midrst_prdata", 64'(prdata), 64'(0));
    model_reset();
    check_outs();
    @(posedge pclk); #1 presetn = 1'b1;
    apb(8'h10, 1'b0, 32'h0);
    apb(8'h44, 1'b0, 32'h0);
    apb(8'h40, 1'b1, 32'h1);
    apb(8'h58, 1'b0, 32'h0);
    apb(8'h54, 1'b0, 32'h0);

    repeat (5) @(posedge pclk);
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("exp_mem_q_drained", 64'(exp_mem_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
